// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation actuator sequencer.
package irrig_pkg;

  localparam int STATE_W = 3;

  // Watering FSM codes; they also appear on the debug state port.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SPRINKLE = 3'd1,
    ST_DRIP     = 3'd2,
    ST_DEAD     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  // Largest of three timing constants, used to size the shared run counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/irrig_tick_gen.sv
// Timebase: free-running divider producing a one-cycle tick every TICK_DIV clocks.
module irrig_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_wrap;

  assign w_wrap = (r_tick_cnt == C_LAST);
  assign tick   = w_wrap;

  // Count 0..TICK_DIV-1 and wrap; the wrap cycle is the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_wrap) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/irrigation_sequencer.sv
// Timed actuator stage: turns raw irrigation requests into safe actuator drives
// with minimum run times, a dead band between watering modes, alarm blinking
// and a latched fault that needs an operator acknowledge.
module irrigation_sequencer
  import irrig_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MIN_ON   = 5,
  parameter int DEAD_T   = 2,
  parameter int BLINK_T  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ve_req,
  input  logic               bs_req,
  input  logic               vs_req,
  input  logic               al_req,
  input  logic               err_req,
  input  logic               ack,
  output logic               ve_out,
  output logic               bs_out,
  output logic               vs_out,
  output logic               al_led,
  output logic               err_led,
  output logic [STATE_W-1:0] state
);

  // One counter width serves the mode timer, the inlet timer and the blink
  // divider; saturating at all-ones keeps every ">= limit" test valid.
  localparam int RUN_MAX = max3(MIN_ON, DEAD_T, BLINK_T);
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [RUN_W-1:0] C_MIN_ON     = RUN_W'(MIN_ON);
  localparam logic [RUN_W-1:0] C_DEAD_T     = RUN_W'(DEAD_T);
  localparam logic [RUN_W-1:0] C_BLINK_LAST = RUN_W'(BLINK_T - 1);
  localparam logic [RUN_W-1:0] C_RUN_SAT    = {RUN_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Input capture: bit order {ack, err, al, vs, bs, ve}
  // ---------------------------------------------------------------------------
  logic [5:0] r_sync1;
  logic [5:0] r_sync2;
  logic       r_ack_d;

  logic w_ve;
  logic w_bs;
  logic w_vs;
  logic w_al;
  logic w_err;
  logic w_ack;
  logic w_ack_p;
  logic w_tick;

  // Two-stage synchronizer for all asynchronous inputs, plus ack history for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_ack_d <= 1'b0;
    end else begin
      r_sync1 <= {ack, err_req, al_req, vs_req, bs_req, ve_req};
      r_sync2 <= r_sync1;
      r_ack_d <= r_sync2[5];
    end
  end

  assign w_ve    = r_sync2[0];
  assign w_bs    = r_sync2[1];
  assign w_vs    = r_sync2[2];
  assign w_al    = r_sync2[3];
  assign w_err   = r_sync2[4];
  assign w_ack   = r_sync2[5];
  assign w_ack_p = w_ack & ~r_ack_d;

  irrig_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  // ---------------------------------------------------------------------------
  // Watering FSM
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_bs_out;
  logic             r_vs_out;
  logic             r_err_led;

  // Next-state rules; an error wins over everything except an already latched fault.
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_err)     w_state_next = ST_FAULT;
        else if (w_bs) w_state_next = ST_SPRINKLE;
        else if (w_vs) w_state_next = ST_DRIP;
        else           w_state_next = ST_IDLE;
      end
      ST_SPRINKLE: begin
        if (w_err)                               w_state_next = ST_FAULT;
        else if (r_run_cnt >= C_MIN_ON && !w_bs) w_state_next = ST_DEAD;
        else                                     w_state_next = ST_SPRINKLE;
      end
      ST_DRIP: begin
        if (w_err)                               w_state_next = ST_FAULT;
        else if (r_run_cnt >= C_MIN_ON && !w_vs) w_state_next = ST_DEAD;
        else                                     w_state_next = ST_DRIP;
      end
      ST_DEAD: begin
        if (w_err)                      w_state_next = ST_FAULT;
        else if (r_run_cnt >= C_DEAD_T) w_state_next = ST_IDLE;
        else                            w_state_next = ST_DEAD;
      end
      ST_FAULT: begin
        if (w_ack_p && !w_err) w_state_next = ST_DEAD;
        else                   w_state_next = ST_FAULT;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register, mode timer and Moore decode of the next state into the drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_run_cnt <= '0;
      r_bs_out  <= 1'b0;
      r_vs_out  <= 1'b0;
      r_err_led <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_run_cnt <= '0;
      end else if (w_tick && r_run_cnt != C_RUN_SAT) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
      r_bs_out  <= (w_state_next == ST_SPRINKLE);
      r_vs_out  <= (w_state_next == ST_DRIP);
      r_err_led <= (w_state_next == ST_FAULT);
    end
  end

  // ---------------------------------------------------------------------------
  // Inlet valve timer
  // ---------------------------------------------------------------------------
  logic             r_ve_out;
  logic [RUN_W-1:0] r_ve_cnt;

  // Inlet valve holds for MIN_ON ticks after it opens; a fault shuts it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ve_out <= 1'b0;
      r_ve_cnt <= '0;
    end else if (w_state_next == ST_FAULT) begin
      r_ve_out <= 1'b0;
      r_ve_cnt <= '0;
    end else if (!r_ve_out) begin
      if (w_ve) begin
        r_ve_out <= 1'b1;
        r_ve_cnt <= '0;
      end
    end else if (!w_ve && r_ve_cnt >= C_MIN_ON) begin
      r_ve_out <= 1'b0;
    end else if (w_tick && r_ve_cnt != C_RUN_SAT) begin
      r_ve_cnt <= r_ve_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm indicator
  // ---------------------------------------------------------------------------
  logic             r_al_led;
  logic             r_al_act;
  logic [RUN_W-1:0] r_blink_cnt;

  // Solid in fault; otherwise blink while al is held, lighting on the first cycle it is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_al_led    <= 1'b0;
      r_al_act    <= 1'b0;
      r_blink_cnt <= '0;
    end else if (w_state_next == ST_FAULT) begin
      r_al_led    <= 1'b1;
      r_al_act    <= 1'b0;
      r_blink_cnt <= '0;
    end else if (!w_al) begin
      r_al_led    <= 1'b0;
      r_al_act    <= 1'b0;
      r_blink_cnt <= '0;
    end else if (!r_al_act) begin
      r_al_led    <= 1'b1;
      r_al_act    <= 1'b1;
      r_blink_cnt <= '0;
    end else if (w_tick) begin
      if (r_blink_cnt >= C_BLINK_LAST) begin
        r_al_led    <= ~r_al_led;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign ve_out  = r_ve_out;
  assign bs_out  = r_bs_out;
  assign vs_out  = r_vs_out;
  assign al_led  = r_al_led;
  assign err_led = r_err_led;
  assign state   = r_state;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Randomized bench for irrigation_sequencer against a tick-arithmetic reference model.
module tb_irrigation_sequencer;

  localparam int TD      = 4;
  localparam int MIN_ON  = 3;
  localparam int DEAD_T  = 2;
  localparam int BLINK_T = 1;
  localparam int N_CYC   = 4000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ve_req = 1'b0, bs_req = 1'b0, vs_req = 1'b0;
  logic       al_req = 1'b0, err_req = 1'b0, ack = 1'b0;
  logic       ve_out, bs_out, vs_out, al_led, err_led;
  logic [2:0] state;

  irrigation_sequencer #(
    .TICK_DIV(TD), .MIN_ON(MIN_ON), .DEAD_T(DEAD_T), .BLINK_T(BLINK_T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ve_req(ve_req), .bs_req(bs_req), .vs_req(vs_req),
    .al_req(al_req), .err_req(err_req), .ack(ack),
    .ve_out(ve_out), .bs_out(bs_out), .vs_out(vs_out),
    .al_led(al_led), .err_led(err_led), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Time is the index k of the clock edge since reset release; a tick is seen
  // at edge k exactly when k is a multiple of TD. Timers are "ticks elapsed
  // since an event edge", computed by division instead of counting.
  int         k;
  logic [5:0] hist [0:8191];   // {ack, err, al, vs, bs, ve} sampled at each edge
  int         m_state, m_entry;
  bit         m_ve_on;  int m_ve_rise;
  bit         m_al_act; int m_al_entry; bit m_al_led;

  function automatic logic [5:0] h(input int idx);
    if (idx < 1) return 6'd0;
    return hist[idx];
  endfunction

  // Number of tick edges in the edge interval (from, to].
  function automatic int ticks_in(input int from, input int to);
    return to / TD - from / TD;
  endfunction

  task automatic model_reset();
    k = 0; m_state = 0; m_entry = 0;
    m_ve_on = 0; m_ve_rise = 0;
    m_al_act = 0; m_al_entry = 0; m_al_led = 0;
  endtask

  task automatic model_step();
    logic [5:0] s, sp;
    bit ve, bs, vs, al, err, ack_p;
    int nxt;
    k++;
    hist[k] = {ack, err_req, al_req, vs_req, bs_req, ve_req};
    s  = h(k - 2);        // what the design sees after two synchronizer stages
    sp = h(k - 3);
    ve = s[0]; bs = s[1]; vs = s[2]; al = s[3]; err = s[4];
    ack_p = s[5] & ~sp[5];

    nxt = m_state;
    case (m_state)
      0: nxt = err ? 4 : bs ? 1 : vs ? 2 : 0;
      1: if (err) nxt = 4; else if (!bs && ticks_in(m_entry, k - 1) >= MIN_ON) nxt = 3;
      2: if (err) nxt = 4; else if (!vs && ticks_in(m_entry, k - 1) >= MIN_ON) nxt = 3;
      3: if (err) nxt = 4; else if (ticks_in(m_entry, k - 1) >= DEAD_T) nxt = 0;
      4: if (ack_p && !err) nxt = 3;
      default: nxt = 0;
    endcase
    if (nxt != m_state) begin
      m_state = nxt;
      m_entry = k;
    end

    if (nxt == 4) m_ve_on = 0;
    else if (!m_ve_on) begin
      if (ve) begin m_ve_on = 1; m_ve_rise = k; end
    end else if (!ve && ticks_in(m_ve_rise, k - 1) >= MIN_ON) m_ve_on = 0;

    if (nxt == 4) begin m_al_led = 1; m_al_act = 0; end
    else if (!al) begin m_al_led = 0; m_al_act = 0; end
    else if (!m_al_act) begin m_al_act = 1; m_al_entry = k; m_al_led = 1; end
    else m_al_led = ((ticks_in(m_al_entry, k) / BLINK_T) % 2) == 0;
  endtask

  function automatic logic [7:0] expected();
    logic [2:0] st;
    st = 3'(m_state);
    return {st, m_ve_on, (m_state == 1), (m_state == 2), m_al_led, (m_state == 4)};
  endfunction

  // ---------------- stimulus ----------------
  int hold [6];

  task automatic drive_random();
    logic [5:0] cur;
    cur = {ack, err_req, al_req, vs_req, bs_req, ve_req};
    for (int i = 0; i < 6; i++) begin
      if (hold[i] == 0) begin
        case (i)
          0: begin cur[i] = $urandom_range(1, 0) == 1; hold[i] = $urandom_range(30, 1); end
          1, 2: begin cur[i] = $urandom_range(1, 0) == 1; hold[i] = $urandom_range(40, 1); end
          3: begin cur[i] = $urandom_range(1, 0) == 1; hold[i] = $urandom_range(60, 5); end
          4: begin cur[i] = $urandom_range(5, 0) == 0; hold[i] = $urandom_range(40, 3); end
          default: begin cur[i] = $urandom_range(3, 0) == 0; hold[i] = $urandom_range(3, 1); end
        endcase
      end
      hold[i]--;
    end
    {ack, err_req, al_req, vs_req, bs_req, ve_req} = cur;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outs", {24'd0, state, ve_out, bs_out, vs_out, al_led, err_led}, {24'd0, expected()});
    check("excl", {31'd0, bs_out & vs_out}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) hold[i] = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", {24'd0, state, ve_out, bs_out, vs_out, al_led, err_led}, 32'd0);
    rst_n = 1'b1;

    // Reach SPRINKLE, then pull reset asynchronously mid-operation
    bs_req = 1'b1;
    repeat (6) run_cycle();
    check("sprinkle", {29'd0, state}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {24'd0, state, ve_out, bs_out, vs_out, al_led, err_led}, 32'd0);
    bs_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Randomized operation
    for (int c = 0; c < N_CYC; c++) begin
      run_cycle();
      drive_random();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
